// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared size codes, state encodings and alignment helper
// Purpose: constants and types used by mem_access_unit and mem_lane_align.
package mem_access_unit_pkg;

  // funct3 access size/sign codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } unit_state_t;

  // Bytes are never misaligned; halves need bit 0 clear; everything else is
  // treated as a word and needs both low bits clear.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic mis;
    case (f3)
      F3_B, F3_BU: mis = 1'b0;
      F3_H, F3_HU: mis = lo[0];
      default:     mis = (lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - ready/valid memory bus between the access unit and memory
// Purpose: bundles the memory request/response signals.
// Ports (master = access unit, slave = memory):
//   mem_req, mem_we, mem_addr, mem_wdata, mem_be : master -> slave
//   mem_ready, mem_rdata                          : slave -> master
interface mem_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_be;
  logic                mem_ready;
  logic [DATA_W-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering for stores and load extraction/extension
// Purpose: combinational; shared by the store and load paths of mem_access_unit.
// Ports:
//   funct3     in  access size/sign
//   lane       in  byte offset within the word (addr[1:0])
//   store_data in  raw store value
//   load_data  in  raw word returned by memory
//   be         out byte enables
//   wdata      out store value replicated into every lane of its size
//   load_val   out selected byte/half/word, sign- or zero-extended
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] store_data,
  input  logic [31:0] load_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_val
);

  logic [31:0] shifted;
  logic        sext;

  always_comb begin
    shifted  = load_data >> {lane, 3'b000};
    // funct3[2] marks the unsigned variants
    sext     = ~funct3[2];
    be       = 4'b1111;
    wdata    = store_data;
    load_val = load_data;
    case (funct3)
      F3_B, F3_BU: begin
        be       = 4'b0001 << lane;
        wdata    = {4{store_data[7:0]}};
        load_val = {{24{sext & shifted[7]}}, shifted[7:0]};
      end
      F3_H, F3_HU: begin
        be       = 4'b0011 << lane;
        wdata    = {2{store_data[15:0]}};
        load_val = {{16{sext & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        be       = 4'b1111;
        wdata    = store_data;
        load_val = load_data;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - control-unit to variable-latency memory access adapter
// Purpose: turns MemRead/MemWrite/IorD/IRWrite into a ready/valid memory
// transaction, loads inst_reg / mdr on read completion and stalls the control
// unit with busy until the access finishes.
// Ports:
//   clk, reset (async, active-low)
//   mem_read, mem_write, i_or_d, ir_write, pc, alu_out, store_data, funct3 : control unit
//   mem (mem_access_unit_if.master) : memory bus
//   inst_reg, mdr            : fetched instruction / extended load data
//   busy, misaligned         : combinational status to the control unit
//   timeout_err              : sticky, set when memory never answers
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic                     i_or_d,
  input  logic                     ir_write,
  input  logic [ADDR_W-1:0]        pc,
  input  logic [ADDR_W-1:0]        alu_out,
  input  logic [DATA_W-1:0]        store_data,
  input  logic [2:0]               funct3,
  mem_access_unit_if.master        mem,
  output logic [DATA_W-1:0]        inst_reg,
  output logic [DATA_W-1:0]        mdr,
  output logic                     busy,
  output logic                     misaligned,
  output logic                     timeout_err
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  unit_state_t state, next_state;

  logic              start;
  logic [ADDR_W-1:0] eff_addr;
  logic [2:0]        eff_f3;
  logic              req_mis;

  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_sd;
  logic [2:0]        hold_f3;
  logic              hold_we;
  logic              hold_ir;

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_sd;
  logic [2:0]        sel_f3;
  logic              sel_we;
  logic              sel_ir;

  logic [3:0]        al_be;
  logic [31:0]       al_wdata;
  logic [31:0]       al_load;

  logic              done;
  logic [CNT_W-1:0]  wait_cnt;

  // Fetches are always word accesses regardless of whatever funct3 is on the bus.
  assign start    = mem_read | mem_write;
  assign eff_addr = i_or_d ? alu_out : pc;
  assign eff_f3   = i_or_d ? funct3 : F3_W;
  assign req_mis  = start & is_misaligned(eff_f3, eff_addr[1:0]);

  // While waiting, the control unit's inputs are ignored and the captured
  // request drives both the bus and the completion path.
  always_comb begin
    sel_addr = eff_addr;
    sel_sd   = store_data;
    sel_f3   = eff_f3;
    sel_we   = mem_write;
    sel_ir   = ir_write;
    if (state == WAIT) begin
      sel_addr = hold_addr;
      sel_sd   = hold_sd;
      sel_f3   = hold_f3;
      sel_we   = hold_we;
      sel_ir   = hold_ir;
    end
  end

  mem_lane_align u_align (
    .funct3     (sel_f3),
    .lane       (sel_addr[1:0]),
    .store_data (sel_sd),
    .load_data  (mem.mem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_val   (al_load)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start && !req_mis && !mem.mem_ready) next_state = WAIT;
      WAIT: begin
        if (mem.mem_ready)          next_state = IDLE;
        else if (wait_cnt == CNT_LAST) next_state = ERR;
      end
      ERR:     next_state = ERR;
      default: next_state = IDLE;
    endcase
  end

  // Outputs; everything combinational is forced low while reset is held so
  // the bus goes quiet the instant reset asserts.
  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    mem.mem_be    = '0;
    busy          = 1'b0;
    misaligned    = 1'b0;
    done          = 1'b0;
    if (reset) begin
      case (state)
        IDLE: begin
          mem.mem_req   = start & ~req_mis;
          mem.mem_we    = start & ~req_mis & mem_write;
          mem.mem_addr  = {sel_addr[ADDR_W-1:2], 2'b00};
          mem.mem_wdata = al_wdata;
          mem.mem_be    = al_be;
          misaligned    = req_mis;
          busy          = start & ~req_mis & ~mem.mem_ready;
          done          = start & ~req_mis & mem.mem_ready;
        end
        WAIT: begin
          mem.mem_req   = 1'b1;
          mem.mem_we    = hold_we;
          mem.mem_addr  = {sel_addr[ADDR_W-1:2], 2'b00};
          mem.mem_wdata = al_wdata;
          mem.mem_be    = al_be;
          busy          = ~mem.mem_ready;
          done          = mem.mem_ready;
        end
        ERR:     busy = 1'b1;
        default: busy = 1'b0;
      endcase
    end
  end

  // Hold registers, result registers, wait counter and sticky timeout
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_addr   <= '0;
      hold_sd     <= '0;
      hold_f3     <= F3_W;
      hold_we     <= 1'b0;
      hold_ir     <= 1'b0;
      inst_reg    <= '0;
      mdr         <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == IDLE && next_state == WAIT) begin
        hold_addr <= eff_addr;
        hold_sd   <= store_data;
        hold_f3   <= eff_f3;
        hold_we   <= mem_write;
        hold_ir   <= ir_write;
      end
      if (done) begin
        wait_cnt <= '0;
        if (!sel_we) begin
          if (sel_ir) inst_reg <= mem.mem_rdata;
          else        mdr      <= al_load;
        end
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt == CNT_LAST) timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard testbench for mem_access_unit
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write, i_or_d, ir_write;
  logic [31:0] pc, alu_out, store_data;
  logic [2:0]  funct3;
  logic [31:0] inst_reg, mdr;
  logic        busy, misaligned, timeout_err;

  mem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) mif ();

  mem_access_unit #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .i_or_d      (i_or_d),
    .ir_write    (ir_write),
    .pc          (pc),
    .alu_out     (alu_out),
    .store_data  (store_data),
    .funct3      (funct3),
    .mem         (mif),
    .inst_reg    (inst_reg),
    .mdr         (mdr),
    .busy        (busy),
    .misaligned  (misaligned),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_ir;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  exp_t        mon_e;
  logic [31:0] mon_act;

  // Scoreboard consumer: every completed read pops one expected register value.
  always @(posedge clk) begin
    if (reset === 1'b1 && mif.mem_req === 1'b1 && mif.mem_ready === 1'b1 && mif.mem_we === 1'b0) begin
      #1;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_completion: got a read completion, required none (mdr=%h inst_reg=%h)", mdr, inst_reg);
      end else begin
        mon_e   = sb_q.pop_front();
        mon_act = mon_e.is_ir ? inst_reg : mdr;
        if (mon_act !== mon_e.val) begin
          errors++;
          $display("FAIL sb_%s: got %h required %h", mon_e.is_ir ? "inst_reg" : "mdr", mon_act, mon_e.val);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic set_idle();
    mem_read = 0; mem_write = 0; i_or_d = 0; ir_write = 0;
    pc = 0; alu_out = 0; store_data = 0; funct3 = F3_W;
    mif.mem_ready = 0; mif.mem_rdata = 0;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 0;
    mem_read = 1; pc = 32'h100; ir_write = 1; mif.mem_ready = 1; mif.mem_rdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (mif.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b required 0", mif.mem_req); end
    checks++; if (mif.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h required 0", mif.mem_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (inst_reg !== 32'h0 || mdr !== 32'h0) begin errors++; $display("FAIL reset_regs: got ir=%h mdr=%h required 0", inst_reg, mdr); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b required 0", timeout_err); end
    set_idle();
    @(negedge clk); reset = 1;
  endtask

  task automatic test_zero_wait_fetch();
    @(negedge clk);
    mem_read = 1; i_or_d = 0; ir_write = 1; pc = 32'h100; funct3 = F3_B;
    mif.mem_ready = 1; mif.mem_rdata = 32'h0050_0093;
    sb_q.push_back('{1'b1, 32'h0050_0093});
    #1;
    checks++; if (mif.mem_addr !== 32'h100) begin errors++; $display("FAIL fetch_addr: got %h required 00000100", mif.mem_addr); end
    checks++; if (busy !== 1'b0 || mif.mem_req !== 1'b1) begin errors++; $display("FAIL fetch_busy_req: got busy=%b req=%b required 0/1", busy, mif.mem_req); end
    @(negedge clk); set_idle();
  endtask

  task automatic test_wait_lw();
    int busy_cnt = 0;
    @(negedge clk);
    mem_read = 1; i_or_d = 1; ir_write = 0; alu_out = 32'h204; funct3 = F3_W;
    mif.mem_ready = 0;
    sb_q.push_back('{1'b0, 32'hDEAD_BEEF});
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(negedge clk);
        alu_out = 32'h0000_0AB0 + 32'(i * 4);
        mem_read = 0;
      end
      if (i == 3) begin mif.mem_ready = 1; mif.mem_rdata = 32'hDEAD_BEEF; end
      #1;
      checks++; if (mif.mem_addr !== 32'h204 || mif.mem_req !== 1'b1) begin errors++; $display("FAIL wait_addr_hold[%0d]: got addr=%h req=%b required 00000204/1", i, mif.mem_addr, mif.mem_req); end
      if (busy === 1'b1) busy_cnt++;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wait_busy_done: got %b required 0", busy); end
    checks++; if (busy_cnt != 3) begin errors++; $display("FAIL wait_busy_cycles: got %0d required 3", busy_cnt); end
    @(negedge clk); set_idle();
  endtask

  task automatic test_lb_lbu();
    logic [2:0]  f3_t [4] = '{F3_B, F3_BU, F3_H, F3_HU};
    logic [31:0] ad_t [4] = '{32'h203, 32'h203, 32'h202, 32'h202};
    logic [31:0] ex_t [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8011, 32'h0000_8011};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_read = 1; i_or_d = 1; ir_write = 0; alu_out = ad_t[i]; funct3 = f3_t[i];
      mif.mem_ready = 1; mif.mem_rdata = 32'h8011_2233;
      sb_q.push_back('{1'b0, ex_t[i]});
      #1;
      checks++; if (busy !== 1'b0 || mif.mem_addr !== 32'h200) begin errors++; $display("FAIL subword_bus[%0d]: got busy=%b addr=%h required 0/00000200", i, busy, mif.mem_addr); end
    end
    @(negedge clk); set_idle();
  endtask

  task automatic test_store();
    logic [31:0] mdr_b, ir_b;
    mdr_b = mdr; ir_b = inst_reg;
    @(negedge clk);
    mem_write = 1; i_or_d = 1; alu_out = 32'h302; funct3 = F3_H; store_data = 32'h0000_ABCD;
    mif.mem_ready = 1; mif.mem_rdata = 32'h1234_5678;
    #1;
    checks++; if (mif.mem_we !== 1'b1 || mif.mem_req !== 1'b1) begin errors++; $display("FAIL sh_we: got we=%b req=%b required 1/1", mif.mem_we, mif.mem_req); end
    checks++; if (mif.mem_be !== 4'b1100) begin errors++; $display("FAIL sh_be: got %b required 1100", mif.mem_be); end
    checks++; if (mif.mem_wdata[31:16] !== 16'hABCD) begin errors++; $display("FAIL sh_wdata: got %h required ABCD", mif.mem_wdata[31:16]); end
    @(posedge clk); #1;
    checks++; if (mdr !== mdr_b || inst_reg !== ir_b) begin errors++; $display("FAIL sh_regs: got mdr=%h ir=%h required %h/%h", mdr, inst_reg, mdr_b, ir_b); end
    @(negedge clk);
    alu_out = 32'h301; funct3 = F3_B; store_data = 32'h0000_005A;
    #1;
    checks++; if (mif.mem_be !== 4'b0010 || mif.mem_wdata[15:8] !== 8'h5A) begin errors++; $display("FAIL sb_lane: got be=%b lane=%h required 0010/5A", mif.mem_be, mif.mem_wdata[15:8]); end
    @(negedge clk);
    mem_read = 1; mem_write = 1; alu_out = 32'h300; funct3 = F3_W; store_data = 32'hCAFE_F00D;
    #1;
    checks++; if (mif.mem_we !== 1'b1 || mif.mem_be !== 4'b1111 || mif.mem_wdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL write_wins: got we=%b be=%b wdata=%h required 1/1111/CAFEF00D", mif.mem_we, mif.mem_be, mif.mem_wdata); end
    @(posedge clk); #1;
    checks++; if (mdr !== mdr_b) begin errors++; $display("FAIL write_wins_mdr: got %h required %h", mdr, mdr_b); end
    @(negedge clk); set_idle();
  endtask

  task automatic test_misaligned();
    logic [31:0] mdr_b;
    mdr_b = mdr;
    @(negedge clk);
    mem_read = 1; i_or_d = 1; alu_out = 32'h401; funct3 = F3_W;
    mif.mem_ready = 1; mif.mem_rdata = 32'h5555_5555;
    #1;
    checks++; if (misaligned !== 1'b1 || mif.mem_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mis_lw: got mis=%b req=%b busy=%b required 1/0/0", misaligned, mif.mem_req, busy); end
    @(posedge clk); #1;
    checks++; if (mdr !== mdr_b) begin errors++; $display("FAIL mis_lw_mdr: got %h required %h", mdr, mdr_b); end
    @(negedge clk);
    alu_out = 32'h203; funct3 = F3_H;
    #1;
    checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL mis_lh: got %b required 1", misaligned); end
    @(negedge clk);
    i_or_d = 0; pc = 32'h102; funct3 = F3_B; ir_write = 1;
    #1;
    checks++; if (misaligned !== 1'b1 || mif.mem_req !== 1'b0) begin errors++; $display("FAIL mis_fetch: got mis=%b req=%b required 1/0", misaligned, mif.mem_req); end
    @(negedge clk);
    i_or_d = 1; ir_write = 0; alu_out = 32'h203; funct3 = F3_B; mif.mem_rdata = 32'h8011_2233;
    sb_q.push_back('{1'b0, 32'hFFFF_FF80});
    #1;
    checks++; if (misaligned !== 1'b0 || mif.mem_req !== 1'b1) begin errors++; $display("FAIL lb_odd_ok: got mis=%b req=%b required 0/1", misaligned, mif.mem_req); end
    @(negedge clk); set_idle();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    mem_read = 1; i_or_d = 0; ir_write = 1; pc = 32'h10;
    mif.mem_ready = 0;
    sb_q.push_back('{1'b1, 32'h1111_1111});
    @(negedge clk);
    mem_read = 0; mif.mem_ready = 1; mif.mem_rdata = 32'h1111_1111;
    @(negedge clk);
    mem_read = 1; i_or_d = 1; ir_write = 0; alu_out = 32'h20; funct3 = F3_W;
    mif.mem_rdata = 32'h2222_2222;
    sb_q.push_back('{1'b0, 32'h2222_2222});
    @(negedge clk);
    alu_out = 32'h26; funct3 = F3_HU; mif.mem_rdata = 32'hF00D_3333;
    sb_q.push_back('{1'b0, 32'h0000_F00D});
    @(negedge clk); set_idle();
  endtask

  task automatic test_random_loads();
    logic [2:0]  codes [5] = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
    logic [2:0]  f3;
    logic [1:0]  lane;
    logic [31:0] rd, ex;
    logic [7:0]  b;
    logic [15:0] h;
    for (int i = 0; i < 12; i++) begin
      f3 = codes[$urandom_range(0, 4)];
      rd = $urandom;
      lane = 2'($urandom_range(0, 3));
      if (f3 == F3_H || f3 == F3_HU) lane = {lane[1], 1'b0};
      if (f3 == F3_W) lane = 2'b00;
      b = rd[lane*8 +: 8];
      h = (lane == 2'b10) ? rd[31:16] : rd[15:0];
      case (f3)
        F3_B:    ex = {{24{b[7]}}, b};
        F3_BU:   ex = {24'h0, b};
        F3_H:    ex = {{16{h[15]}}, h};
        F3_HU:   ex = {16'h0, h};
        default: ex = rd;
      endcase
      @(negedge clk);
      mem_read = 1; i_or_d = 1; ir_write = 0; funct3 = f3; alu_out = 32'h600 | 32'(lane);
      mif.mem_ready = 1; mif.mem_rdata = rd;
      sb_q.push_back('{1'b0, ex});
    end
    @(negedge clk); set_idle();
  endtask

  task automatic test_timeout();
    int n = 0;
    @(negedge clk);
    mem_read = 1; i_or_d = 1; alu_out = 32'h500; funct3 = F3_W; mif.mem_ready = 0;
    @(posedge clk); #1;
    while (n < 40 && timeout_err !== 1'b1) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (timeout_err !== 1'b1 || n != 15) begin errors++; $display("FAIL timeout_cycles: got err=%b after %0d wait cycles required 1 after 15", timeout_err, n); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1 || mif.mem_req !== 1'b0) begin errors++; $display("FAIL err_state: got busy=%b req=%b required 1/0", busy, mif.mem_req); end
    @(negedge clk); reset = 0; #1;
    checks++; if (timeout_err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL err_reset: got err=%b busy=%b required 0/0", timeout_err, busy); end
    set_idle();
    @(negedge clk); reset = 1;
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    mem_read = 1; mem_write = 1; i_or_d = 1; alu_out = 32'h504; funct3 = F3_W;
    store_data = 32'hAAAA_5555; mif.mem_ready = 0;
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (busy !== 1'b1 || mif.mem_req !== 1'b1) begin errors++; $display("FAIL midwait_pre: got busy=%b req=%b required 1/1", busy, mif.mem_req); end
    reset = 0; #1;
    checks++; if (mif.mem_req !== 1'b0 || mif.mem_we !== 1'b0 || mif.mem_addr !== 32'h0 || mif.mem_be !== 4'h0 || mif.mem_wdata !== 32'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL midwait_reset: got req=%b we=%b addr=%h be=%b wdata=%h busy=%b required all 0", mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_be, mif.mem_wdata, busy);
    end
    set_idle();
    @(negedge clk); reset = 1; #1;
    checks++; if (mif.mem_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midwait_idle: got req=%b busy=%b required 0/0", mif.mem_req, busy); end
    @(negedge clk);
    mem_read = 1; i_or_d = 1; alu_out = 32'h700; funct3 = F3_W;
    mif.mem_ready = 1; mif.mem_rdata = 32'h1234_5678;
    sb_q.push_back('{1'b0, 32'h1234_5678});
    @(negedge clk); set_idle();
  endtask

  initial begin
    test_reset();
    test_zero_wait_fetch();
    test_wait_lw();
    test_lb_lbu();
    test_store();
    test_misaligned();
    test_back_to_back();
    test_random_loads();
    test_timeout();
    test_reset_mid_wait();
    repeat (2) @(negedge clk);
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d pending required 0", sb_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits between the multi-cycle control unit and a unified instruction/data memory with variable latency.
- Turns the per-state memory controls (MemRead, MemWrite, IorD, IRWrite) into a ready/valid memory transaction.
- Latches fetched instructions into the instruction register and load data into the MDR, with RISC-V byte/half/word sizing.
- Returns a combinational stall (busy) so the control unit holds its current state until the access completes.

Parameters:
- ADDR_W, 32, memory address width
- DATA_W, 32, memory data width (fixed at 32; byte enables are DATA_W/8)
- MAX_WAIT, 15, maximum wait cycles tolerated before timeout error

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- mem_read  in  1  MemRead from control unit
- mem_write  in  1  MemWrite from control unit
- i_or_d  in  1  0: address=pc, 1: address=alu_out
- ir_write  in  1  completed read is loaded into inst_reg
- pc  in  ADDR_W  current PC
- alu_out  in  ADDR_W  data address
- store_data  in  DATA_W  rs2 value for stores
- funct3  in  3  access size/sign (000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu)
- mem_req  out  1  request valid to memory
- mem_we  out  1  write request
- mem_addr  out  ADDR_W  word-aligned address ({addr[31:2],2'b00})
- mem_wdata  out  DATA_W  store data shifted to byte lane
- mem_be  out  DATA_W/8  byte enables
- mem_ready  in  1  memory completes current request this cycle
- mem_rdata  in  DATA_W  read data, valid when mem_ready=1
- inst_reg  out  DATA_W  instruction register
- mdr  out  DATA_W  memory data register (extended load value)
- busy  out  1  stall to control unit
- misaligned  out  1  current request is misaligned (combinational)
- timeout_err  out  1  sticky timeout flag

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, inst_reg=0, mdr=0, timeout_err=0, wait counter=0.
  - All outputs are 0 while in reset.
- Access definitions:
  - start = mem_read|mem_write; mem_write wins if both are asserted.
  - eff_addr = i_or_d ? alu_out : pc.
  - Instruction fetches (i_or_d=0) are always treated as word accesses.
- Misalignment:
  - Half access with eff_addr[0]=1, or word access with eff_addr[1:0]!=0, sets misaligned=1.
  - A misaligned access issues no mem_req, sets busy=0 and updates no register.
- State IDLE:
  - mem_req = start & ~misaligned; mem_addr, mem_wdata and mem_be are driven combinationally from the inputs.
  - If mem_ready is high in the same cycle: the access completes (zero-wait), busy=0, and the registers load at the edge.
  - Otherwise busy=1 and the next state is WAIT; the address, wdata, be, we, ir_write and funct3 are captured into hold registers.
- State WAIT:
  - Outputs are driven from the hold registers; mem_req=1; control inputs are ignored.
  - busy = ~mem_ready; on mem_ready the access completes and the next state is IDLE.
  - The wait counter increments each cycle without mem_ready.
  - On reaching MAX_WAIT: timeout_err<=1 and the next state is ERR.
- State ERR:
  - mem_req=0, busy=1 permanently; leaves only on reset.
- Completion of a read:
  - If ir_write: inst_reg <= mem_rdata.
  - Else: mdr <= the selected byte/half (lane = addr[1:0]), sign- or zero-extended per funct3.
- Completion of a write:
  - mem_be: sb=4'b0001<<addr[1:0], sh=4'b0011<<addr[1:0], sw=4'b1111.
  - mem_wdata = store_data replicated into the addressed lane.
  - inst_reg and mdr are unchanged.
- The wait counter is cleared on every completion.
- A reset asserted mid-WAIT aborts the access immediately; the memory must tolerate a dropped request.

Decomposition:
- Shared package/header (alongside opcodes.v):
  - FUNCT3 size codes.
  - Unit state encodings IDLE/WAIT/ERR.
- Natural sub-module: mem_lane_align, combinational. It generates mem_be, shifts store data into lanes, and extracts/extends load data. It is reused for both store and load paths.

Test Plan:
- Zero-wait fetch: mem_read=1, i_or_d=0, ir_write=1, pc=0x100, mem_ready=1 in the same cycle, rdata=0x00500093.
  -> mem_addr=0x100, busy=0, inst_reg=0x00500093 the next cycle.
- 3-wait-cycle lw: alu_out=0x204, ready after 3 cycles, rdata=0xDEADBEEF.
  -> busy=1 for 3 cycles, mem_addr held at 0x204 even when alu_out changes, mdr=0xDEADBEEF after completion.
- lb sign vs lbu: addr=0x203, rdata=0x80112233.
  -> lb gives mdr=0xFFFFFF80, lbu gives 0x00000080.
- sh at 0x302, store_data=0x0000ABCD.
  -> mem_we=1, mem_be=4'b1100, mem_wdata upper half=0xABCD, mdr/inst_reg unchanged.
- Misaligned lw at 0x401.
  -> misaligned=1, mem_req=0, busy=0.
- Timeout with MAX_WAIT=15: ready never asserted.
  -> timeout_err=1 after 15 wait cycles, busy stays 1.
  -> Assert reset mid-wait: all outputs 0 immediately, state IDLE.
